// File: rtl/mem_access_unit.sv
// MEM-stage load/store sequencer: alignment check, req/ack data-bus access, right-aligned load return.
// Latency: IDLE+BUSY+RESP = 3 cycles minimum, +1 per ack wait; stall holds the pipe until RESP or abort.
module mem_access_unit #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        mem_valid_i,
   input  logic        mem_read_i,
   input  logic        mem_write_i,
   input  logic [1:0]  mem_size_i,
   input  logic        mem_sign_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] mem_wdata_i,
   output logic        stall_o,
   output logic        misalign_o,
   output logic        bus_timeout_o,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [3:0]  bus_be_o,
   output logic [31:0] bus_wdata_o,
   input  logic        bus_ack_i,
   input  logic [31:0] bus_rdata_i,
   output logic        ld_valid_o,
   output logic [31:0] ld_data_o,
   output logic [3:0]  ld_be_o,
   output logic        ld_op_o
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          we_q, we_d;
   logic [31:0]   addr_q, addr_d;
   logic [1:0]    off_q, off_d;
   logic [1:0]    size_q, size_d;
   logic          sign_q, sign_d;
   logic [3:0]    be_q, be_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   ld_data_q, ld_data_d;
   logic [3:0]    ld_be_q, ld_be_d;
   logic          ld_op_q, ld_op_d;
   logic          ld_valid_q, ld_valid_d;
   logic          misalign_q, misalign_d;
   logic          timeout_q, timeout_d;

   logic          access;
   logic          aligned;
   logic [3:0]    be_nxt;
   logic [31:0]   wdata_nxt;
   logic [3:0]    ld_code;
   logic          timeout_hit;

   assign access = mem_valid_i & (mem_read_i | mem_write_i);

   // Size 11 falls into the word case because only bit 1 is tested first.
   always_comb begin
      aligned   = 1'b1;
      be_nxt    = 4'b1111;
      wdata_nxt = mem_wdata_i;
      if (mem_size_i[1]) begin
         aligned = (mem_addr_i[1:0] == 2'b00);
      end else if (mem_size_i[0]) begin
         aligned   = ~mem_addr_i[0];
         be_nxt    = mem_addr_i[1] ? 4'b1100 : 4'b0011;
         wdata_nxt = {2{mem_wdata_i[15:0]}};
      end else begin
         be_nxt    = 4'b0001 << mem_addr_i[1:0];
         wdata_nxt = {4{mem_wdata_i[7:0]}};
      end
   end

   assign ld_code     = size_q[1] ? 4'b1111 : (size_q[0] ? 4'b1100 : 4'b1000);
   assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      we_d       = we_q;
      addr_d     = addr_q;
      off_d      = off_q;
      size_d     = size_q;
      sign_d     = sign_q;
      be_d       = be_q;
      wdata_d    = wdata_q;
      ld_data_d  = ld_data_q;
      ld_be_d    = ld_be_q;
      ld_op_d    = ld_op_q;
      ld_valid_d = 1'b0;
      misalign_d = 1'b0;
      timeout_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (access) begin
               if (aligned) begin
                  we_d    = mem_write_i;
                  addr_d  = {mem_addr_i[31:2], 2'b00};
                  off_d   = mem_addr_i[1:0];
                  size_d  = mem_size_i;
                  sign_d  = mem_sign_i;
                  be_d    = be_nxt;
                  wdata_d = wdata_nxt;
                  cnt_d   = '0;
                  state_d = S_BUSY;
               end else begin
                  misalign_d = 1'b1;
               end
            end
         end
         S_BUSY: begin
            cnt_d = cnt_q + CW'(1);
            // Ack takes priority over an expiring counter in the same cycle.
            if (bus_ack_i) begin
               state_d = S_RESP;
               if (!we_q) begin
                  ld_data_d  = bus_rdata_i >> {off_q, 3'b000};
                  ld_be_d    = ld_code;
                  ld_op_d    = sign_q;
                  ld_valid_d = 1'b1;
               end
            end else if (timeout_hit) begin
               state_d   = S_IDLE;
               timeout_d = 1'b1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         off_q      <= '0;
         size_q     <= '0;
         sign_q     <= 1'b0;
         be_q       <= '0;
         wdata_q    <= '0;
         ld_data_q  <= '0;
         ld_be_q    <= '0;
         ld_op_q    <= 1'b0;
         ld_valid_q <= 1'b0;
         misalign_q <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         off_q      <= off_d;
         size_q     <= size_d;
         sign_q     <= sign_d;
         be_q       <= be_d;
         wdata_q    <= wdata_d;
         ld_data_q  <= ld_data_d;
         ld_be_q    <= ld_be_d;
         ld_op_q    <= ld_op_d;
         ld_valid_q <= ld_valid_d;
         misalign_q <= misalign_d;
         timeout_q  <= timeout_d;
      end
   end

   assign bus_req_o     = (state_q == S_BUSY);
   assign stall_o       = (state_q == S_BUSY) | ((state_q == S_IDLE) & access & aligned);
   assign bus_we_o      = we_q;
   assign bus_addr_o    = addr_q;
   assign bus_be_o      = be_q;
   assign bus_wdata_o   = wdata_q;
   assign misalign_o    = misalign_q;
   assign bus_timeout_o = timeout_q;
   assign ld_valid_o    = ld_valid_q;
   assign ld_data_o     = ld_data_q;
   assign ld_be_o       = ld_be_q;
   assign ld_op_o       = ld_op_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus randomized accesses checked
// against a transaction-level model of lanes, alignment and access length.
module tb_mem_access_unit;
   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_valid, mem_read, mem_write, mem_sign;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr, mem_wdata;
   logic        stall, misalign, bus_timeout, bus_req, bus_we;
   logic [31:0] bus_addr, bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_ack;
   logic [31:0] bus_rdata;
   logic        ld_valid, ld_op;
   logic [31:0] ld_data;
   logic [3:0]  ld_be;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int resp_cyc = 0;

   logic [31:0] m_ld_data;
   logic [3:0]  m_ld_be;
   logic        m_ld_op;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_access_unit #(.TIMEOUT(TO)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .mem_valid_i(mem_valid), .mem_read_i(mem_read), .mem_write_i(mem_write),
      .mem_size_i(mem_size), .mem_sign_i(mem_sign), .mem_addr_i(mem_addr),
      .mem_wdata_i(mem_wdata), .stall_o(stall), .misalign_o(misalign),
      .bus_timeout_o(bus_timeout), .bus_req_o(bus_req), .bus_we_o(bus_we),
      .bus_addr_o(bus_addr), .bus_be_o(bus_be), .bus_wdata_o(bus_wdata),
      .bus_ack_i(bus_ack), .bus_rdata_i(bus_rdata), .ld_valid_o(ld_valid),
      .ld_data_o(ld_data), .ld_be_o(ld_be), .ld_op_o(ld_op)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", tag, got, exp, cyc);
      end
   endtask

   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'd0) ? 1 : ((sz == 2'd1) ? 2 : 4);
   endfunction

   function automatic bit is_aligned(input logic [1:0] sz, input logic [31:0] a);
      return (int'(a[1:0]) % nbytes(sz)) == 0;
   endfunction

   function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
      logic [3:0] be = '0;
      int off = int'(a[1:0]);
      for (int k = 0; k < 4; k++)
         if (k >= off && k < off + nbytes(sz)) be[k] = 1'b1;
      return be;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
      logic [31:0] w = '0;
      for (int k = 0; k < 4; k++) w[8*k +: 8] = wd[8*(k % nbytes(sz)) +: 8];
      return w;
   endfunction

   function automatic logic [3:0] m_ldcode(input logic [1:0] sz);
      int n = nbytes(sz);
      return (n == 4) ? 4'b1111 : ((n == 2) ? 4'b1100 : 4'b1000);
   endfunction

   task automatic check_hold();
      check("ld_data", ld_data, m_ld_data);
      check("ld_be", 32'(ld_be), 32'(m_ld_be));
      check("ld_op", 32'(ld_op), 32'(m_ld_op));
   endtask

   task automatic idle_inputs();
      mem_valid = 1'b0;
      mem_read  = 1'($urandom);
      mem_write = 1'($urandom);
      mem_size  = 2'($urandom);
      mem_sign  = 1'($urandom);
      mem_addr  = $urandom;
      mem_wdata = $urandom;
      bus_ack   = 1'($urandom);
      bus_rdata = $urandom;
   endtask

   // Ack is raised in BUSY cycle index 'waits'; waits >= TO means the bus never answers.
   task automatic access(input bit rd, input logic [1:0] sz, input bit sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int waits, input logic [31:0] rdata);
      bit al = is_aligned(sz, a);
      bit acked = 1'b0;
      int stalls = 0;
      @(negedge clk);
      mem_valid = 1'b1; mem_read = rd; mem_write = !rd; mem_size = sz;
      mem_sign = sg; mem_addr = a; mem_wdata = wd;
      bus_ack = 1'($urandom); bus_rdata = $urandom;
      #1;
      check("idle_stall", 32'(stall), 32'(al));
      check("idle_req", 32'(bus_req), 0);
      check("idle_ldv", 32'(ld_valid), 0);
      check_hold();
      if (stall) stalls++;
      if (!al) begin
         @(negedge clk); idle_inputs(); #1;
         check("misalign", 32'(misalign), 1);
         check("mis_req", 32'(bus_req), 0);
         check("mis_stall", 32'(stall), 0);
         @(negedge clk); idle_inputs(); #1;
         check("misalign_end", 32'(misalign), 0);
         check("mis_req2", 32'(bus_req), 0);
         return;
      end
      for (int i = 0; i < TO && !acked; i++) begin
         @(negedge clk);
         mem_valid = 1'b1; mem_read = 1'($urandom); mem_write = !mem_read;
         mem_size = 2'($urandom); mem_sign = 1'($urandom);
         mem_addr = $urandom; mem_wdata = $urandom;
         bus_ack = (i == waits);
         bus_rdata = (i == waits) ? rdata : $urandom;
         #1;
         check("busy_req", 32'(bus_req), 1);
         check("busy_stall", 32'(stall), 1);
         check("bus_we", 32'(bus_we), 32'(!rd));
         check("bus_addr", bus_addr, {a[31:2], 2'b00});
         check("bus_be", 32'(bus_be), 32'(m_be(sz, a)));
         if (!rd) check("bus_wdata", bus_wdata, m_wdata(sz, wd));
         check("busy_tmo", 32'(bus_timeout), 0);
         check_hold();
         stalls++;
         if (i == waits) acked = 1'b1;
      end
      @(negedge clk);
      if (acked) begin
         idle_inputs();
         mem_valid = 1'($urandom);
         if (rd) begin
            m_ld_data = rdata >> (8 * int'(a[1:0]));
            m_ld_be   = m_ldcode(sz);
            m_ld_op   = sg;
            resp_cyc  = cyc;
         end
      end else begin
         idle_inputs();
      end
      #1;
      check("end_req", 32'(bus_req), 0);
      check("end_stall", 32'(stall), 0);
      check("end_ldv", 32'(ld_valid), 32'(acked && rd));
      check("end_tmo", 32'(bus_timeout), 32'(!acked));
      check("stall_cycles", stalls, acked ? waits + 2 : TO + 1);
      check_hold();
      if (!acked) begin
         @(negedge clk); idle_inputs(); #1;
         check("tmo_end", 32'(bus_timeout), 0);
         check("tmo_ldv", 32'(ld_valid), 0);
      end
   endtask

   initial begin
      int c1;
      rst_n = 1'b0;
      idle_inputs();
      bus_ack = 1'b0;
      m_ld_data = '0; m_ld_be = '0; m_ld_op = 1'b0;
      #1;
      check("rst_stall", 32'(stall), 0);
      check("rst_req", 32'(bus_req), 0);
      check("rst_mis", 32'(misalign), 0);
      check("rst_tmo", 32'(bus_timeout), 0);
      check("rst_ldv", 32'(ld_valid), 0);
      check("rst_we", 32'(bus_we), 0);
      check("rst_addr", bus_addr, 0);
      check("rst_be", 32'(bus_be), 0);
      check("rst_wdata", bus_wdata, 0);
      check_hold();
      @(negedge clk); rst_n = 1'b1;

      // lb sign-extended from the top lane with two wait cycles
      access(1'b1, 2'b00, 1'b1, 32'h0000_1003, 32'h0, 2, 32'h80FF_1234);
      check("t1_byte", 32'(ld_data[7:0]), 32'h80);
      check("t1_ldbe", 32'(ld_be), 32'b1000);
      // sh to upper half, zero-wait
      access(1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h0000_BEEF, 0, 32'h0);
      // misaligned lw
      access(1'b1, 2'b10, 1'b0, 32'h0000_3002, 32'h0, 0, 32'h0);
      // lw with no ack -> abort
      access(1'b1, 2'b10, 1'b0, 32'h0000_4000, 32'h0, 99, 32'h0);

      // reset while BUSY
      @(negedge clk);
      mem_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_size = 2'b10;
      mem_addr = 32'h0000_4010; bus_ack = 1'b0;
      @(negedge clk);
      mem_valid = 1'b0; bus_ack = 1'b0;
      #1;
      check("pre_rst_req", 32'(bus_req), 1);
      rst_n = 1'b0;
      #1;
      m_ld_data = '0; m_ld_be = '0; m_ld_op = 1'b0;
      check("arst_req", 32'(bus_req), 0);
      check("arst_stall", 32'(stall), 0);
      check_hold();
      @(negedge clk); rst_n = 1'b1;
      access(1'b1, 2'b01, 1'b0, 32'h0000_5002, 32'h0, 0, 32'hABCD_0000);
      check("t5_half", 32'(ld_data[15:0]), 32'hABCD);

      // back-to-back zero-wait loads
      access(1'b1, 2'b10, 1'b0, 32'h0000_6000, 32'h0, 0, 32'h1111_2222);
      c1 = resp_cyc;
      access(1'b1, 2'b10, 1'b1, 32'h0000_6004, 32'h0, 0, 32'h3333_4444);
      check("b2b_spacing", resp_cyc - c1, 3);

      // randomized accesses with idle gaps; ack outside BUSY must be ignored
      for (int n = 0; n < 60; n++) begin
         int gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            @(negedge clk); idle_inputs(); #1;
            check("gap_req", 32'(bus_req), 0);
            check("gap_stall", 32'(stall), 0);
            check("gap_ldv", 32'(ld_valid), 0);
            check_hold();
         end
         access(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom,
                $urandom_range(0, TO), $urandom);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
